fir_tdm_mac: RTL and testbench
==============================

Name: fir_tdm_mac

Overview:
- Multi-channel, time-multiplexed FIR filter in the DSP datapath; the successor to the fixed 4-tap parallel FIR.
- One shared multiplier-accumulator computes TAP_NUMBER taps sequentially.
- Each channel keeps its own delay line. Coefficients are runtime-programmable.
- Valid/ready handshakes on input and output. Output is rounded, rescaled and saturated to OUT_WIDTH.

Parameters:
- DATA_WIDTH, 16: signed input sample width.
- COEF_WIDTH, 16: signed coefficient width.
- TAP_NUMBER, 8: taps per channel, ≥2.
- NUM_CH, 2: independent channels, ≥1.
- OUT_WIDTH, 16: signed output width.
- SHIFT, 14: right shift applied to the accumulator (coefficient fractional bits), ≥1.
- Derived localparams: CH_W=max(1,clog2(NUM_CH)), TAP_W=clog2(TAP_NUMBER), ACC_WIDTH=DATA_WIDTH+COEF_WIDTH+TAP_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  DATA_WIDTH  signed sample
- in_ch  in  CH_W  channel of sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  TAP_W  tap index
- coef_data  in  COEF_WIDTH  signed coefficient
- coef_drop  out  1  one-cycle pulse: write ignored
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_WIDTH  filtered sample
- out_ch  out  CH_W  channel of result
- out_sat  out  1  result was saturated (qualified by out_valid)
- busy  out  1  state != IDLE

Behaviour:
- Reset (async): all outputs 0; state IDLE; all delay lines 0; coef[0]=1<<SHIFT, others 0 (identity filter); accumulator 0.
- FSM states:
  - IDLE: in_ready=1. On in_valid with in_ch<NUM_CH: shift that channel's line (tap0 ← in_data, tap k ← tap k-1), latch channel, acc=0, k=0, go to MAC. On in_valid with in_ch≥NUM_CH: handshake completes, sample discarded, stay IDLE.
  - MAC: one tap per cycle, acc += line[ch][k]*coef[k] using the already-shifted line. After k=TAP_NUMBER-1, register the result and go to OUT.
  - OUT: out_valid=1; out_data, out_ch and out_sat held stable. On out_ready, go to IDLE next cycle.
- in_ready=0 in MAC and OUT.
- Latency: sample accepted at edge t → out_valid high from cycle t+TAP_NUMBER+1. Maximum throughput is one sample per TAP_NUMBER+2 cycles.
- Arithmetic:
  - Full-precision signed products; ACC_WIDTH accumulator, no internal overflow.
  - Result r = (acc + (1<<(SHIFT-1))) >>> SHIFT (round half up).
  - If r > 2^(OUT_WIDTH-1)-1 or r < -2^(OUT_WIDTH-1), clamp to the limit and set out_sat=1.
- Coefficient writes:
  - Take effect at the clock edge, but only in IDLE.
  - In IDLE with in_valid and coef_we in the same cycle, both take effect and the new coefficient is used for that sample.
  - coef_we outside IDLE: write ignored, coef_drop pulses for one cycle.
- Coefficients are shared across all channels.
- Backpressure: out_ready low holds OUT indefinitely; no sample is lost and none is accepted.
- Reset mid-MAC or mid-OUT: immediate return to reset state; the partial result is lost and out_valid drops asynchronously.

Decomposition:
- Package fir_pkg: FSM state enum (IDLE, MAC, OUT) and a saturating-round function parameterised by widths and shift.
- One natural sub-module: fir_mac_unit (multiply, accumulate, round, saturate; clear/enable controls).
- Delay lines and FSM stay in the top level.

Test Plan:
- Identity after reset (defaults): ch0 samples 100, -5, 32767 → out_data 100, -5, 32767; out_sat=0; out_valid 9 cycles after each accept.
- Rounding: write coef[0]=1, others 0; inputs 8192, 8191, -8192, -8193 → 1, 0, 0, -1.
- Channel isolation: coef[1]=16384, coef[0]=0. Sequence ch0=10, ch1=20, ch0=30, ch1=40 → outputs 0, 0, 10 (ch0), 20 (ch1).
- Saturation: coef[0]=coef[1]=32767; ch0 inputs 32767, 32767 → second out_data=32767, out_sat=1. coef[0]=-32768 with input -32768 → 32767, out_sat=1.
- Backpressure and drop: hold out_ready=0 for 5 cycles → out_valid and out_data stable, in_ready=0. A coef_we during this time → coef_drop pulse, coefficient unchanged.
- Reset mid-MAC: assert rst on the 3rd MAC cycle → outputs 0 immediately. After release, one input 50 → out 50 (identity restored, history cleared).

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed FIR filter.
// Holds the controller state encoding and the round/rescale/saturate step.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Round half up, arithmetic shift right, then clamp to a signed out_width range.
    function automatic logic signed [63:0] sat_round(
        input  logic signed [63:0] acc,
        input  int                 shift,
        input  int                 out_width,
        output logic               sat
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r   = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        hi  = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (out_width - 1));
        sat = 1'b0;
        if (r > hi) begin
            r   = hi;
            sat = 1'b1;
        end else if (r < lo) begin
            r   = lo;
            sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Shared multiply-accumulate engine: one tap product per enabled cycle, with the
// rounded and saturated result captured on the last tap.
module fir_mac_unit
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int ACC_WIDTH  = 35,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 14
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         en,
    input  logic                         last,
    input  logic signed [DATA_WIDTH-1:0] sample,
    input  logic signed [COEF_WIDTH-1:0] coef,
    output logic signed [OUT_WIDTH-1:0]  result,
    output logic                         result_sat
);

    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;

    logic signed [PROD_W-1:0]    prod;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_sum;
    logic signed [63:0]          rounded;
    logic                        rounded_sat;

    // The last product is folded in combinationally so the result lands with the final tap.
    always_comb begin
        rounded_sat = 1'b0;
        prod        = PROD_W'(sample) * PROD_W'(coef);
        acc_sum     = acc + ACC_WIDTH'(prod);
        rounded     = sat_round(64'(acc_sum), SHIFT, OUT_WIDTH, rounded_sat);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            result     <= '0;
            result_sat <= 1'b0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_sum;
            if (last) begin
                result     <= OUT_WIDTH'(rounded);
                result_sat <= rounded_sat;
            end
        end
    end

endmodule

// File: rtl/fir_tdm_mac.sv
// Multi-channel FIR with one shared MAC: per-channel delay lines, shared runtime
// coefficients, valid/ready on both sides, rounded and saturated output.
module fir_tdm_mac
    import fir_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int COEF_WIDTH = 16,
    parameter  int TAP_NUMBER = 8,
    parameter  int NUM_CH     = 2,
    parameter  int OUT_WIDTH  = 16,
    parameter  int SHIFT      = 14,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int TAP_W      = $clog2(TAP_NUMBER),
    localparam int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + TAP_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic [CH_W-1:0]              in_ch,
    input  logic                         coef_we,
    input  logic [TAP_W-1:0]             coef_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_data,
    output logic                         coef_drop,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic [CH_W-1:0]              out_ch,
    output logic                         out_sat,
    output logic                         busy
);

    // Handshake: a transfer happens on a rising clk edge where valid and ready are both
    // high; valid never waits on ready, and out_data/out_ch/out_sat hold while out_valid
    // is high and out_ready is low.

    state_t state;
    state_t state_nxt;

    logic [CH_W-1:0]               ch;
    logic [TAP_W-1:0]              k;
    logic signed [DATA_WIDTH-1:0]  line [NUM_CH][TAP_NUMBER];
    logic signed [COEF_WIDTH-1:0]  coef [TAP_NUMBER];

    logic accept;
    logic ch_ok;
    logic addr_ok;
    logic last_tap;
    logic mac_en;

    assign ch_ok    = {1'b0, in_ch} < (CH_W + 1)'(NUM_CH);
    assign addr_ok  = {1'b0, coef_addr} < (TAP_W + 1)'(TAP_NUMBER);
    assign last_tap = (k == TAP_W'(TAP_NUMBER - 1));
    assign busy     = (state != IDLE);
    assign out_valid = (state == OUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Out-of-range channels complete the handshake but are dropped without leaving IDLE.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        mac_en    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && ch_ok) begin
                    accept    = 1'b1;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (last_tap) state_nxt = OUT;
            end
            OUT: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++)
                for (int t = 0; t < TAP_NUMBER; t++)
                    line[c][t] <= '0;
            for (int t = 1; t < TAP_NUMBER; t++)
                coef[t] <= '0;
            coef[0]   <= COEF_WIDTH'(1 << SHIFT);
            ch        <= '0;
            k         <= '0;
            out_ch    <= '0;
            coef_drop <= 1'b0;
        end else begin
            if (accept) begin
                for (int t = TAP_NUMBER - 1; t > 0; t--)
                    line[in_ch][t] <= line[in_ch][t-1];
                line[in_ch][0] <= in_data;
                ch <= in_ch;
                k  <= '0;
            end else if (mac_en) begin
                k <= k + TAP_W'(1);
                if (last_tap) out_ch <= ch;
            end
            // Coefficients are only rewritten between samples so a running sum never mixes sets.
            if (coef_we && state == IDLE && addr_ok)
                coef[coef_addr] <= coef_data;
            coef_drop <= coef_we && (state != IDLE);
        end
    end

    fir_mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .SHIFT      (SHIFT)
    ) u_mac (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept),
        .en         (mac_en),
        .last       (last_tap),
        .sample     (line[ch][k]),
        .coef       (coef[k]),
        .result     (out_data),
        .result_sat (out_sat)
    );

endmodule

// File: tb/tb_fir_tdm_mac.sv
// Randomized scoreboard bench for fir_tdm_mac against an arithmetic reference model.
module tb_fir_tdm_mac;

    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int TAPS = 8;
    localparam int NCH  = 2;
    localparam int OW   = 16;
    localparam int SH   = 14;
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW   = $clog2(TAPS);
    localparam int W    = 1 + CHW + OW;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic [CHW-1:0]       in_ch;
    logic                 coef_we;
    logic [TW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_data;
    logic                 coef_drop;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_data;
    logic [CHW-1:0]       out_ch;
    logic                 out_sat;
    logic                 busy;

    fir_tdm_mac #(
        .DATA_WIDTH (DW),
        .COEF_WIDTH (CW),
        .TAP_NUMBER (TAPS),
        .NUM_CH     (NCH),
        .OUT_WIDTH  (OW),
        .SHIFT      (SH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ch     (in_ch),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .coef_drop (coef_drop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    // clock / reset block
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    int           n_total = 0;
    int           n_pass  = 0;
    int           last_acc = 0;
    logic         prev_valid = 1'b0;
    bit           rand_ready = 1'b0;
    bit           force_ready = 1'b1;

    // reference model: delay lines and coefficients as plain integers
    longint m_line [NCH][TAPS];
    longint m_coef [TAPS];

    task automatic model_reset();
        for (int c = 0; c < NCH; c++)
            for (int t = 0; t < TAPS; t++)
                m_line[c][t] = 0;
        for (int t = 0; t < TAPS; t++) m_coef[t] = 0;
        m_coef[0] = longint'(1) << SH;
    endtask

    function automatic logic [W-1:0] model_push(input int ch, input longint data);
        longint sum, r, hi, lo;
        logic   sat;
        for (int t = TAPS - 1; t > 0; t--) m_line[ch][t] = m_line[ch][t-1];
        m_line[ch][0] = data;
        sum = 0;
        for (int t = 0; t < TAPS; t++) sum += m_line[ch][t] * m_coef[t];
        r   = (sum + (longint'(1) << (SH - 1))) >>> SH;
        hi  = (longint'(1) << (OW - 1)) - 1;
        lo  = -(longint'(1) << (OW - 1));
        sat = 1'b0;
        if (r > hi) begin r = hi; sat = 1'b1; end
        else if (r < lo) begin r = lo; sat = 1'b1; end
        return {sat, CHW'(ch), OW'(r)};
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    // driver tasks
    task automatic send(input int ch, input int data, input bit we = 1'b0,
                        input int addr = 0, input int cd = 0);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_wait", in_ready, 1);
            return;
        end
        in_valid  = 1'b1;
        in_data   = DW'(data);
        in_ch     = CHW'(ch);
        coef_we   = we;
        coef_addr = TW'(addr);
        coef_data = CW'(cd);
        if (we) m_coef[addr] = cd;
        last_acc = cyc;
        lat_q.push_back(cyc);
        exp_q.push_back(model_push(ch, data));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
    endtask

    task automatic write_coef(input int addr, input int cd);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("coef_idle_wait", in_ready, 1);
            return;
        end
        coef_we   = 1'b1;
        coef_addr = TW'(addr);
        coef_data = CW'(cd);
        m_coef[addr] = cd;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_exp_q", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        lat_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // downstream ready generator
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
        end
    end

    // monitor: latency of each result and its contents against the expected queue
    initial begin : monitor
        logic [W-1:0] e;
        int a;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (out_valid && !prev_valid) begin
                    if (lat_q.size() == 0) chk("valid_without_accept", lat_q.size(), 1);
                    else begin
                        a = lat_q.pop_front();
                        chk("latency", cyc, a + TAPS + 1);
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk("output_without_expect", exp_q.size(), 1);
                    else begin
                        e = exp_q.pop_front();
                        chk("out_data", out_data, $signed(e[OW-1:0]));
                        chk("out_ch", out_ch, e[OW+CHW-1:OW]);
                        chk("out_sat", out_sat, e[W-1]);
                    end
                end
                prev_valid = out_valid;
            end
        end
    end

    initial begin : main
        int n;
        int cd;
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_ch = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_coef_drop", coef_drop, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);

        // identity filter out of reset
        send(0, 100); send(0, -5); send(0, 32767);
        drain();

        // rounding at the half-LSB boundaries
        write_coef(0, 1);
        send(0, 8192); send(0, 8191); send(0, -8192); send(0, -8193);
        drain();

        // channel isolation from a clean history
        do_reset();
        write_coef(0, 0); write_coef(1, 16384);
        send(0, 10); send(1, 20); send(0, 30); send(1, 40);
        drain();

        // saturation, positive overflow and most-negative squared
        write_coef(0, 32767); write_coef(1, 32767);
        send(0, 32767); send(0, 32767);
        write_coef(1, 0); write_coef(0, -32768);
        send(0, -32768);
        // coefficient write in the same cycle as the sample
        send(1, 1000, 1'b1, 0, 16384);
        drain();

        // backpressure with an ignored coefficient write
        force_ready = 1'b0;
        send(0, 1234);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_wait", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", out_data, $signed(exp_q[0][OW-1:0]));
            chk("bp_in_ready", in_ready, 0);
            if (i == 1) begin
                coef_we = 1'b1; coef_addr = '0; coef_data = CW'(777);
            end
            if (i == 2) begin
                coef_we = 1'b0;
                chk("drop_pulse", coef_drop, 1);
            end
            if (i == 3) chk("drop_one_cycle", coef_drop, 0);
        end
        force_ready = 1'b1;
        drain();
        send(0, 1000);
        drain();

        // asynchronous reset in the third MAC cycle
        force_ready = 1'b1;
        send(0, 777);
        n = 0;
        while (cyc < last_acc + 3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid_mac_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_sat", out_sat, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        exp_q.delete();
        lat_q.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        send(0, 50);
        drain();

        // randomized traffic with random backpressure and coefficient updates
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) cd = int'($urandom_range(0, 65535)) - 32768;
            else cd = int'($urandom_range(0, 16384)) - 8192;
            if ($urandom_range(0, 4) == 0)
                write_coef(int'($urandom_range(0, TAPS - 1)), cd);
            send(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 65535)) - 32768,
                 $urandom_range(0, 5) == 0, int'($urandom_range(0, TAPS - 1)), cd);
        end
        rand_ready = 1'b0;
        force_ready = 1'b1;
        drain();
        chk("lat_q_empty", lat_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
